conv_mac_array: RTL
===================

# conv_mac_array

Parametrised KPF×CPF multiply-accumulate engine for convolution layers. It is the generalised successor of the fixed-size per-layer MAC lanes. Each cycle it takes one CPF-wide input vector and KPF weight vectors, and accumulates over a multi-beat vector terminated by `op_din_eop`. On `op_din_eop` it adds per-kernel bias, rounds, saturates and optionally applies ReLU. It emits one packed KPF-wide result through a credit-protected output FIFO with ready/valid backpressure. It sits between the row/weight/bias RAMs and the layer's `blob_dout` port.

## Interface
- CPF, 4, input channels per beat
- KPF, 8, kernels (output lanes) computed in parallel
- DIN_DW, 16, signed input width
- WW, 16, signed weight width
- BIAS_DW, 16, signed bias width
- DOUT_DW, 16, signed output width
- ACC_WIDTH, 40, accumulator width; must be ≥ DIN_DW+WW+clog2(CPF)+1
- DIN_Q / W_Q / BIAS_Q / DOUT_Q, 6/13/6/6, fractional bits; require BIAS_Q ≤ DIN_Q+W_Q and DOUT_Q < DIN_Q+W_Q
- OUT_DEPTH, 4, output FIFO entries (power of two, ≥ 2)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- relu_en  in  1  ReLU mode, sampled with the first beat of each vector
- op_din_en  in  1  input beat valid
- op_din_rdy  out  1  beat accepted when op_din_en && op_din_rdy
- op_din_eop  in  1  last beat of the accumulation vector
- op_din_last  in  1  marks the vector as last of the blob; sampled with the eop beat
- op_din  in  CPF*DIN_DW  channel c at [c*DIN_DW +: DIN_DW]
- op_weight  in  KPF*CPF*WW  kernel k, channel c at [(k*CPF+c)*WW +: WW]
- op_bias  in  KPF*BIAS_DW  kernel k bias, sampled with the eop beat
- dout_en  out  1  FIFO head valid
- dout_rdy  in  1  consumer ready; pop on dout_en && dout_rdy
- dout_eop  out  1  op_din_last of the head result
- dout  out  KPF*DOUT_DW  lane k at [k*DOUT_DW +: DOUT_DW]

## Operation
- Pipeline stages:
  - S1 registers CPF×KPF signed products (DIN_DW+WW bits each) plus the tags en, eop, first, last, relu and bias.
  - S2 registers the per-kernel sum of the CPF products, sign-extended to ACC_WIDTH.
  - S3 accumulates: acc_k = first ? sum_k : acc_k + sum_k. The accumulator wraps modulo 2^ACC_WIDTH with no overflow detection.
  - S4 runs only on eop-tagged beats, as described below.
- first is set for the first accepted beat after reset or after an eop beat. A single beat carrying eop is a complete one-beat vector.
- S4 steps, per kernel k:
  - b = sign-extend(bias_k) << (DIN_Q+W_Q−BIAS_Q).
  - t = acc_k + b.
  - r = (t + 2^(SH−1)) >>> SH, where SH = DIN_Q+W_Q−DOUT_Q (arithmetic shift).
  - Saturate r to [−2^(DOUT_DW−1), 2^(DOUT_DW−1)−1].
  - If relu, clamp negative values to 0.
  - Write {last, packed result} into the FIFO.
- Credit counter:
  - Resets to OUT_DEPTH.
  - Decrements on an accepted eop beat; increments on a pop; unchanged if both occur in the same cycle.
  - op_din_rdy = (credit ≠ 0). This gates all beats, so the FIFO can never overflow and results in flight never exceed free entries.
- Non-accepted beats (op_din_en && !op_din_rdy) are ignored entirely and cause no state change.

## Timing
- Latency: an eop beat accepted in cycle t writes the FIFO at the end of cycle t+3. dout_en rises in cycle t+4 when the FIFO was empty.
- Throughput: one beat per cycle while credit ≠ 0; back-to-back one-beat vectors give one result per cycle.
- dout/dout_eop hold stable while dout_en && !dout_rdy.
- Simultaneous FIFO write and pop are allowed when full or empty, because credits guarantee space.
- Reset (asynchronous assert, synchronous deassert supplied externally) values:
  - dout_en = 0, dout = 0, dout_eop = 0, op_din_rdy = 1 (credit = OUT_DEPTH).
  - All pipeline tags cleared, accumulators 0, first = 1.
- Reset mid-vector discards partial accumulations and FIFO contents. The first beat after reset starts a new vector.

## Structure
- Shared package `accdnn_pkg`:
  - `sat_round` function (width-generic via parameters).
  - clog2 helper.
  - Q-format checks as elaboration-time assertions.
- Sub-module `sync_fifo` (WIDTH = KPF*DOUT_DW+1, DEPTH = OUT_DEPTH), first-word-fall-through.
- The credit counter and pipeline live in conv_mac_array.

## Test plan
Parameters CPF=4, KPF=2, DIN_Q=W_Q=DOUT_Q=6 (SH=6), BIAS_Q=6 unless noted.
- Unit gain: one eop beat, all din=64, all weights=64, bias 0 → dout_en at t+4, both lanes = 256.
- Bias and rounding:
  - Lane 0: din0=1, w=32, others 0, bias 0 → raw 32 → output 1.
  - Lane 1: w=31 → raw 31 → output 0; then bias 64 → output 64.
- Multi-beat with saturation and ReLU:
  - 3 beats, din=32767, w=32767 → lane output 32767.
  - Negated weights with relu_en=1 → 0; with relu_en=0 → −32768.
- Backpressure:
  - Hold dout_rdy=0 and stream 6 one-beat vectors → op_din_rdy drops after the 4th eop.
  - The 5th beat is ignored until a pop.
  - Release dout_rdy → 4 results drain in order, then the 5th result appears.
- Reset mid-vector: assert rst during beat 2 of 3 → outputs cleared, op_din_rdy=1. A following single eop beat yields only its own sum.
- dout_eop: op_din_last=1 on the 3rd of 3 vectors → dout_eop=1 only on the 3rd result.

Source files
------------

// File: rtl/accdnn_pkg.sv
// accdnn_pkg: helpers shared by the accelerator datapath blocks.
//   clog2       - ceiling log2 for sizing counters and pointers
//   sat_round   - round-half-up arithmetic right shift followed by signed
//                 saturation to an arbitrary output width
//   q_format_ok / acc_width_ok - elaboration-time legality checks for the
//                 fixed-point formats and the accumulator width
package accdnn_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // The bias must not carry more fractional bits than the products, and the
  // output must drop at least one fractional bit so rounding is meaningful.
  function automatic bit q_format_ok(input int din_q, input int w_q,
                                     input int bias_q, input int dout_q);
    return (bias_q <= din_q + w_q) && (dout_q < din_q + w_q);
  endfunction

  function automatic bit acc_width_ok(input int acc_w, input int din_dw,
                                      input int ww, input int cpf);
    return acc_w >= din_dw + ww + clog2(cpf) + 1;
  endfunction

  // Adds 2^(sh-1), shifts right arithmetically by sh, then clamps to the
  // signed range of out_w bits. The caller truncates to out_w bits.
  function automatic logic signed [63:0] sat_round(input logic signed [63:0] t,
                                                   input int sh,
                                                   input int out_w);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    if (sh > 0) r = (t + (64'sd1 <<< (sh - 1))) >>> sh;
    else        r = t;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (r > hi)      r = hi;
    else if (r < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through synchronous FIFO.
//   clk, rst      - clock, asynchronous active-low reset (storage cleared)
//   wr_en/wr_data - write port; the producer guarantees space
//   rd_en         - pop the head; ignored while empty
//   rd_data       - current head (valid while not_empty)
//   not_empty     - head valid
module sync_fifo
  import accdnn_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             not_empty
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_rd;

  assign do_rd     = rd_en && (count != '0);
  assign not_empty = (count != '0);
  assign rd_data   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two. A write and a
  // pop in the same cycle while full is safe: the slot overwritten is the
  // head being popped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/conv_mac_array.sv
// conv_mac_array: KPF x CPF multiply-accumulate engine for convolution layers.
//   clk, rst       - clock, asynchronous active-low reset
//   relu_en        - ReLU mode, taken from the first beat of each vector
//   op_din_en/rdy  - input beat handshake
//   op_din_eop     - last beat of an accumulation vector
//   op_din_last    - last vector of the blob (taken with the eop beat)
//   op_din         - CPF channels, channel c at [c*DIN_DW +: DIN_DW]
//   op_weight      - kernel k, channel c at [(k*CPF+c)*WW +: WW]
//   op_bias        - kernel k bias (taken with the eop beat)
//   dout_en/rdy    - output handshake from the result FIFO head
//   dout_eop       - blob-last flag of the head result
//   dout           - KPF lanes, lane k at [k*DOUT_DW +: DOUT_DW]
//
// Handshake rule (both ports): a transfer happens on a rising edge where
// valid (op_din_en / dout_en) and ready (op_din_rdy / dout_rdy) are both
// high; a valid beat that is not accepted leaves all state untouched, and
// dout/dout_eop are held stable while dout_en is high without dout_rdy.
//
// Pipeline: S1 products, S2 per-kernel sums, S3 accumulators, S4 bias /
// round / saturate / ReLU (combinational from S3) into the FIFO write.
module conv_mac_array
  import accdnn_pkg::*;
#(
  parameter int CPF       = 4,
  parameter int KPF       = 8,
  parameter int DIN_DW    = 16,
  parameter int WW        = 16,
  parameter int BIAS_DW   = 16,
  parameter int DOUT_DW   = 16,
  parameter int ACC_WIDTH = 40,
  parameter int DIN_Q     = 6,
  parameter int W_Q       = 13,
  parameter int BIAS_Q    = 6,
  parameter int DOUT_Q    = 6,
  parameter int OUT_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     relu_en,
  input  logic                     op_din_en,
  output logic                     op_din_rdy,
  input  logic                     op_din_eop,
  input  logic                     op_din_last,
  input  logic [CPF*DIN_DW-1:0]    op_din,
  input  logic [KPF*CPF*WW-1:0]    op_weight,
  input  logic [KPF*BIAS_DW-1:0]   op_bias,
  output logic                     dout_en,
  input  logic                     dout_rdy,
  output logic                     dout_eop,
  output logic [KPF*DOUT_DW-1:0]   dout
);

  localparam int PW  = DIN_DW + WW;
  localparam int SH  = DIN_Q + W_Q - DOUT_Q;
  localparam int BSH = DIN_Q + W_Q - BIAS_Q;
  localparam int CRW = clog2(OUT_DEPTH) + 1;
  localparam int FW  = KPF * DOUT_DW + 1;

  if (!q_format_ok(DIN_Q, W_Q, BIAS_Q, DOUT_Q)) begin : g_bad_q
    $error("conv_mac_array: illegal Q formats");
  end
  if (!acc_width_ok(ACC_WIDTH, DIN_DW, WW, CPF)) begin : g_bad_acc
    $error("conv_mac_array: ACC_WIDTH too small");
  end
  if (OUT_DEPTH < 2 || (OUT_DEPTH & (OUT_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("conv_mac_array: OUT_DEPTH must be a power of two >= 2");
  end

  logic [CRW-1:0] credit;
  logic           accept;
  logic           pop;
  logic           first_q;
  logic           relu_hold;
  logic           vec_relu;

  logic                        s1_en, s1_eop, s1_first, s1_last, s1_relu;
  logic [KPF*BIAS_DW-1:0]      s1_bias;
  logic signed [PW-1:0]        s1_prod [KPF][CPF];

  logic                        s2_en, s2_eop, s2_first, s2_last, s2_relu;
  logic [KPF*BIAS_DW-1:0]      s2_bias;
  logic signed [ACC_WIDTH-1:0] s2_sum [KPF];
  logic signed [ACC_WIDTH-1:0] sum_d  [KPF];

  logic                        s3_fire, s3_last, s3_relu;
  logic [KPF*BIAS_DW-1:0]      s3_bias;
  logic signed [ACC_WIDTH-1:0] acc [KPF];

  logic [KPF*DOUT_DW-1:0]      res;
  logic [DOUT_DW-1:0]          lane_val;

  // A credit stands for a free FIFO slot not yet claimed by an eop beat in
  // flight, so gating every beat on it keeps the FIFO from overflowing.
  assign op_din_rdy = (credit != '0);
  assign accept     = op_din_en && op_din_rdy;
  assign pop        = dout_en && dout_rdy;
  assign vec_relu   = first_q ? relu_en : relu_hold;

  always_comb begin
    for (int k = 0; k < KPF; k++) begin
      sum_d[k] = '0;
      for (int c = 0; c < CPF; c++) begin
        sum_d[k] = sum_d[k] + ACC_WIDTH'(s1_prod[k][c]);
      end
    end
  end

  // Bias is aligned to the product's fractional point before the add; the
  // sum is formed in 64 bits so only the accumulator itself wraps.
  always_comb begin
    res      = '0;
    lane_val = '0;
    for (int k = 0; k < KPF; k++) begin
      lane_val = DOUT_DW'(sat_round(
                   64'(acc[k]) +
                   (64'($signed(s3_bias[k*BIAS_DW +: BIAS_DW])) <<< BSH),
                   SH, DOUT_DW));
      if (s3_relu && lane_val[DOUT_DW-1]) lane_val = '0;
      res[k*DOUT_DW +: DOUT_DW] = lane_val;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit    <= CRW'(OUT_DEPTH);
      first_q   <= 1'b1;
      relu_hold <= 1'b0;
      s1_en <= 1'b0; s1_eop <= 1'b0; s1_first <= 1'b0; s1_last <= 1'b0; s1_relu <= 1'b0;
      s1_bias <= '0;
      s2_en <= 1'b0; s2_eop <= 1'b0; s2_first <= 1'b0; s2_last <= 1'b0; s2_relu <= 1'b0;
      s2_bias <= '0;
      s3_fire <= 1'b0; s3_last <= 1'b0; s3_relu <= 1'b0;
      s3_bias <= '0;
      for (int k = 0; k < KPF; k++) begin
        s2_sum[k] <= '0;
        acc[k]    <= '0;
        for (int c = 0; c < CPF; c++) s1_prod[k][c] <= '0;
      end
    end else begin
      case ({accept && op_din_eop, pop})
        2'b10:   credit <= credit - CRW'(1);
        2'b01:   credit <= credit + CRW'(1);
        default: credit <= credit;
      endcase

      // S1
      s1_en <= accept;
      if (accept) begin
        first_q   <= op_din_eop;
        relu_hold <= vec_relu;
        s1_eop    <= op_din_eop;
        s1_first  <= first_q;
        s1_last   <= op_din_last;
        s1_relu   <= vec_relu;
        s1_bias   <= op_bias;
        for (int k = 0; k < KPF; k++) begin
          for (int c = 0; c < CPF; c++) begin
            s1_prod[k][c] <= $signed(op_din[c*DIN_DW +: DIN_DW]) *
                             $signed(op_weight[(k*CPF+c)*WW +: WW]);
          end
        end
      end

      // S2
      s2_en <= s1_en;
      if (s1_en) begin
        s2_eop   <= s1_eop;
        s2_first <= s1_first;
        s2_last  <= s1_last;
        s2_relu  <= s1_relu;
        s2_bias  <= s1_bias;
        for (int k = 0; k < KPF; k++) s2_sum[k] <= sum_d[k];
      end

      // S3: accumulators restart on the first beat, wrap otherwise
      s3_fire <= s2_en && s2_eop;
      if (s2_en) begin
        for (int k = 0; k < KPF; k++) begin
          acc[k] <= s2_first ? s2_sum[k] : acc[k] + s2_sum[k];
        end
      end
      if (s2_en && s2_eop) begin
        s3_last <= s2_last;
        s3_relu <= s2_relu;
        s3_bias <= s2_bias;
      end
    end
  end

  logic [FW-1:0] fifo_head;

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (s3_fire),
    .wr_data   ({s3_last, res}),
    .rd_en     (pop),
    .rd_data   (fifo_head),
    .not_empty (dout_en)
  );

  assign dout_eop = fifo_head[FW-1];
  assign dout     = fifo_head[FW-2:0];

endmodule
